// File: rtl/uart_tx_fifo.sv
// First-word-fall-through FIFO between a host and a UART transmitter. Status flags come from registered pointers only.
// Defining UART_TX_FIFO_LEVEL_EN adds the `level` output, which reports the registered occupancy.
module uart_tx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush,
  output logic                    almost_full,
  output logic                    empty,
`ifdef UART_TX_FIFO_LEVEL_EN
  output logic                    full,
  output logic [$clog2(DEPTH):0]  level
`else
  output logic                    full
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [AW:0]           occ;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  wr_en, rd_en;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign occ         = wr_ptr_q - rd_ptr_q;
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign almost_full = (occ >= (AW+1)'(AFULL_LEVEL));
  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign out_data    = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_en = in_valid && !full && !flush;
  assign rd_en = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately not reset; out_data is meaningless while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end

`ifdef UART_TX_FIFO_LEVEL_EN
  assign level = occ;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: the driver queues accepted writes, and a negedge monitor checks status and read data.
module tb_uart_tx_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;
  logic          almost_full, empty, full;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
`endif

  uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .flush(flush), .almost_full(almost_full),
    .empty(empty),
`ifdef UART_TX_FIFO_LEVEL_EN
    .full(full), .level(level)
`else
    .full(full)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] exp_q[$];
  int            model_occ = 0;
  int            checks = 0;
  int            errors = 0;
  bit            run = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus. Occupancy is captured before this cycle's write is queued.
  task automatic drive(input bit iv, input logic [DW-1:0] d, input bit ordy, input bit fl);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    model_occ = exp_q.size();
    if (fl) exp_q.delete();
    else if (iv && model_occ < DEPTH) exp_q.push_back(d);
  endtask

  // The monitor runs at the negedge, with the inputs for the coming edge already applied.
  always @(negedge clk) begin
    if (rst_n && run) begin
      chk("empty", 32'(empty), 32'(model_occ == 0));
      chk("full", 32'(full), 32'(model_occ == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(model_occ >= AFULL));
      chk("in_ready", 32'(in_ready), 32'(model_occ != DEPTH));
      chk("out_valid", 32'(out_valid), 32'(model_occ != 0));
`ifdef UART_TX_FIFO_LEVEL_EN
      chk("level", 32'(level), 32'(model_occ));
`endif
      if (!flush && model_occ > 0 && exp_q.size() > 0)
        chk("head_data", 32'(out_data), 32'(exp_q[0]));
      if (!flush && out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_read", 32'(1), 32'(0));
        else void'(exp_q.pop_front());
      end
    end
  end

  task automatic async_reset_pulse();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_full", 32'(full), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_almost_full", 32'(almost_full), 32'(0));
    exp_q.delete();
    model_occ = 0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #2;
    chk("por_empty", 32'(empty), 32'(1));
    chk("por_full", 32'(full), 32'(0));
    chk("por_almost_full", 32'(almost_full), 32'(0));
    chk("por_in_ready", 32'(in_ready), 32'(1));
    chk("por_out_valid", 32'(out_valid), 32'(0));
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("por_level", 32'(level), 32'(0));
`endif
    #10 rst_n = 1'b1;
    run = 1'b1;

    // Three bytes held behind out_ready=0, then drained in order.
    drive(1, 8'h41, 0, 0);
    drive(1, 8'h42, 0, 0);
    drive(1, 8'h43, 0, 0);
    drive(0, 8'h00, 0, 0);
    drive(0, 8'h00, 0, 0);
    chk("fwft_head", 32'(out_data), 32'h41);
    repeat (3) drive(0, 8'h00, 1, 0);
    drive(0, 8'h00, 0, 0);

    // Fill to full; the 17th offer must be rejected.
    for (int i = 0; i < DEPTH; i++) drive(1, 8'(i), 0, 0);
    drive(1, 8'hFF, 0, 0);
    drive(0, 8'h00, 0, 0);

    // Full with both sides active: only the read completes, and the write goes in on the next cycle.
    drive(1, 8'h10, 1, 0);
    drive(1, 8'h10, 0, 0);
    drive(0, 8'h00, 0, 0);

    // Drain to 4 entries, then run 40 cycles of simultaneous read and write.
    repeat (12) drive(0, 8'h00, 1, 0);
    for (int i = 0; i < 40; i++) drive(1, 8'(8'h80 + i), 1, 0);
    drive(0, 8'h00, 0, 0);

    // Flush 5 entries while a write is offered in the same cycle.
    repeat (DEPTH) drive(0, 8'h00, 1, 0);
    for (int i = 0; i < 5; i++) drive(1, 8'(8'h20 + i), 0, 0);
    drive(1, 8'hEE, 0, 1);
    drive(0, 8'h00, 0, 0);
    drive(0, 8'h00, 0, 0);

    // Asynchronous reset with 7 entries stored.
    for (int i = 0; i < 7; i++) drive(1, 8'(8'h30 + i), 0, 0);
    drive(0, 8'h00, 0, 0);
    async_reset_pulse();
    repeat (3) drive(0, 8'h00, 1, 0);
    drive(1, 8'h5A, 0, 0);
    drive(0, 8'h00, 1, 0);
    drive(0, 8'h00, 0, 0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 40) == 0));
    repeat (DEPTH + 2) drive(0, 8'h00, 1, 0);
    drive(0, 8'h00, 0, 0);
    @(negedge clk);
    #1;
    chk("final_drained", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of each stored byte/word.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries; power of two, at least 2.
REQ-003 SHALL have parameter AFULL_LEVEL, default 12, occupancy at or above which almost_full asserts; range 1..DEPTH.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_data, input, DATA_WIDTH, write data from the host.
REQ-007 SHALL have port in_valid, input, 1, host offers in_data.
REQ-008 SHALL have port in_ready, output, 1, FIFO accepts a write; equals !full.
REQ-009 SHALL have port out_data, output, DATA_WIDTH, head entry toward the UART TX data input.
REQ-010 SHALL have port out_valid, output, 1, head entry valid; equals !empty.
REQ-011 SHALL have port out_ready, input, 1, UART TX consumes the head (driven by TX ready).
REQ-012 SHALL have port flush, input, 1, synchronous discard of all contents.
REQ-013 SHALL have port almost_full, output, 1, occupancy >= AFULL_LEVEL.
REQ-014 SHALL have port empty, output, 1, occupancy == 0.
REQ-015 SHALL have port full, output, 1, occupancy == DEPTH.

Function
REQ-016 SHALL complete a write on a rising edge where in_valid && in_ready, storing in_data at the write pointer.
REQ-017 SHALL complete a read on a rising edge where out_valid && out_ready, advancing the read pointer.
REQ-018 SHALL be first-word-fall-through: out_data equals the oldest entry whenever out_valid=1, with no read-request cycle.
REQ-019 SHALL present a word written on edge N at out_valid/out_data after edge N, i.e. one cycle write-to-read latency, with no same-cycle bypass.
REQ-020 SHALL keep out_data stable while out_valid=1 && out_ready=0.
REQ-021 SHALL use read and write pointers of log2(DEPTH)+1 bits that wrap modulo 2*DEPTH; full is MSBs differing with lower bits equal, empty is pointers equal.
REQ-022 SHALL maintain occupancy = wr_ptr - rd_ptr modulo 2*DEPTH, range 0..DEPTH.
REQ-023 SHALL, on a simultaneous read and write when 0 < occupancy < DEPTH, perform both and leave occupancy unchanged.
REQ-024 SHALL, when full, perform no write (in_ready=0); a same-cycle read still completes, and in_ready rises on the following cycle.
REQ-025 SHALL, when empty, perform no read (out_valid=0); a same-cycle write completes.
REQ-026 SHALL, on flush=1 at an edge, zero both pointers and ignore any same-cycle read or write, so empty=1 and in_ready=1 on the next cycle.
REQ-027 SHALL drive all status outputs (full, empty, almost_full, in_ready, out_valid) from registered pointers only, so they carry no combinational path from in_valid or out_ready.

Reset
REQ-028 SHALL, while rst_n=0, force wr_ptr=0, rd_ptr=0, empty=1, full=0, almost_full=0, out_valid=0, in_ready=1, irrespective of clk.
REQ-029 SHALL leave storage array contents unreset; out_data is don't-care while out_valid=0.
REQ-030 SHALL, on reset assertion mid-operation, discard all entries, with the first post-reset write behaving as into an empty FIFO.

Configuration
REQ-031 SHALL, with macro UART_TX_FIFO_LEVEL_EN defined, add output port level, log2(DEPTH)+1 bits, equal to registered occupancy, reset to 0 and cleared by flush.
REQ-032 SHALL, without UART_TX_FIFO_LEVEL_EN, omit the level port and its logic, with all other behaviour identical.

Verification
REQ-033 SHALL cover: after reset, write 0x41,0x42,0x43 with out_ready=0 -> empty=0, out_data=0x41; then out_ready=1 for 3 cycles -> reads 0x41,0x42,0x43 in order, then empty=1.
REQ-034 SHALL cover: DEPTH=16, 16 writes 0x00..0x0F with out_ready=0 -> full=1, in_ready=0, almost_full=1 from the 12th write; a 17th in_valid of 0xFF is not stored.
REQ-035 SHALL cover: full FIFO, in_valid=1 and out_ready=1 in the same cycle -> read 0x00 only, occupancy 15; the next cycle in_ready=1 and the write completes.
REQ-036 SHALL cover: continuous simultaneous read/write for 40 cycles with an incrementing pattern -> pointers wrap at least twice, output sequence is exact, occupancy is constant.
REQ-037 SHALL cover: 5 entries stored, flush=1 with in_valid=1 -> next cycle empty=1, and level=0 when UART_TX_FIFO_LEVEL_EN is defined.
REQ-038 SHALL cover: rst_n pulsed low asynchronously between edges with 7 entries stored -> empty=1 and out_valid=0 immediately, with no spurious read afterwards.
